multiplier_q: RTL and testbench

MULTIPLIER_Q -- requirements
Module: multiplier_q

---
 rtl/multiplier_q.sv | 123 ++++++++++++
 tb/tb_multiplier_q.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_q.sv
// Signed Q-format multiplier: iterative shift-add over DATA_W cycles, followed by
// optional round-half-up, arithmetic shift by FRAC_W and saturate-or-wrap output.
module multiplier_q #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 13,
    parameter bit          SAT_EN = 1'b1,
    parameter bit          RND_EN = 1'b0
) (
    input  logic              I_CLK,
    input  logic              I_RST,
    input  logic              I_VLD,
    input  logic [DATA_W-1:0] I_M1,
    input  logic [DATA_W-1:0] I_M2,
    output logic              O_VLD,
    output logic              O_MUL_BUSY,
    output logic [DATA_W-1:0] O_PRODUCT,
    output logic              O_OVF
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam int unsigned PW   = 2 * DATA_W;
    localparam logic [PW:0] RndInc = RND_EN ? ((PW+1)'(1) << (FRAC_W - 1)) : '0;
    localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]      m1_q, m1_d;
    logic signed [DATA_W:0] hi_q, hi_d;
    logic [DATA_W-1:0]      lo_q, lo_d;
    logic [DATA_W-1:0]      prod_q, prod_d;
    logic                   ovf_q, ovf_d;

    logic                   last;
    logic signed [DATA_W:0] m1_ext, addend, sum;
    logic [PW-1:0]          full;
    logic signed [PW:0]     rnd, shf;
    logic                   in_rng;
    logic [DATA_W-1:0]      prod_res;

    // Datapath: hi holds the running partial sum, lo shifts out multiplier bits
    // and fills with product low bits. The MSB of the multiplier has negative weight.
    always_comb begin
        last   = (cnt_q == CntW'(DATA_W - 1));
        m1_ext = {m1_q[DATA_W-1], m1_q};
        addend = lo_q[0] ? (last ? -m1_ext : m1_ext) : '0;
        sum    = hi_q + addend;
        full   = {sum, lo_q[DATA_W-1:1]};
        rnd    = $signed({full[PW-1], full}) + $signed(RndInc);
        shf    = rnd >>> FRAC_W;
        in_rng = (&shf[PW:DATA_W-1]) | ~(|shf[PW:DATA_W-1]);
        if (SAT_EN) begin
            if (in_rng) begin
                prod_res = shf[DATA_W-1:0];
            end else begin
                prod_res = rnd[PW] ? MinNeg : MaxPos;
            end
        end else begin
            prod_res = {rnd[PW], shf[DATA_W-2:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m1_d    = m1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (I_VLD) begin
                    m1_d    = I_M1;
                    lo_d    = I_M2;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                hi_d  = {sum[DATA_W], sum[DATA_W:1]};
                lo_d  = {sum[0], lo_q[DATA_W-1:1]};
                cnt_d = cnt_q + CntW'(1);
                if (last) begin
                    prod_d  = prod_res;
                    ovf_d   = ~in_rng;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            m1_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m1_q    <= m1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
        end
    end

    assign O_VLD      = (state_q == StDone);
    assign O_MUL_BUSY = (state_q != StIdle);
    assign O_PRODUCT  = prod_q;
    assign O_OVF      = ovf_q;

endmodule

// File: tb/tb_multiplier_q.sv
// Bench for multiplier_q: four parameterisations (16/13 and 8/4, sat/wrap, trunc/round)
// checked against a longint reference model through per-DUT scoreboards.
module tb_multiplier_q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vld16, vld8;
    logic [15:0] m1_16, m2_16;
    logic [7:0]  m1_8, m2_8;

    logic        vld_a, busy_a, ovf_a, vld_b, busy_b, ovf_b;
    logic        vld_c, busy_c, ovf_c, vld_d, busy_d, ovf_d;
    logic [15:0] prod_a, prod_b;
    logic [7:0]  prod_c, prod_d;

    int checks = 0;
    int errors = 0;

    logic [32:0] qa[$], qb[$], qc[$], qd[$];
    logic [32:0] ea, eb, ec, ed;

    multiplier_q #(.DATA_W(16), .FRAC_W(13), .SAT_EN(1'b1), .RND_EN(1'b0)) u_a (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld16), .I_M1(m1_16), .I_M2(m2_16),
        .O_VLD(vld_a), .O_MUL_BUSY(busy_a), .O_PRODUCT(prod_a), .O_OVF(ovf_a));
    multiplier_q #(.DATA_W(16), .FRAC_W(13), .SAT_EN(1'b0), .RND_EN(1'b1)) u_b (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld16), .I_M1(m1_16), .I_M2(m2_16),
        .O_VLD(vld_b), .O_MUL_BUSY(busy_b), .O_PRODUCT(prod_b), .O_OVF(ovf_b));
    multiplier_q #(.DATA_W(8), .FRAC_W(4), .SAT_EN(1'b1), .RND_EN(1'b0)) u_c (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld8), .I_M1(m1_8), .I_M2(m2_8),
        .O_VLD(vld_c), .O_MUL_BUSY(busy_c), .O_PRODUCT(prod_c), .O_OVF(ovf_c));
    multiplier_q #(.DATA_W(8), .FRAC_W(4), .SAT_EN(1'b0), .RND_EN(1'b1)) u_d (
        .I_CLK(clk), .I_RST(rst), .I_VLD(vld8), .I_M1(m1_8), .I_M2(m2_8),
        .O_VLD(vld_d), .O_MUL_BUSY(busy_d), .O_PRODUCT(prod_d), .O_OVF(ovf_d));

    function automatic logic [32:0] model(int w, int f, bit sat, bit rnd,
                                          logic [31:0] x, logic [31:0] y);
        longint a, b, p, r, s, mx, mn, mask, res;
        bit ovf;
        mask = (longint'(1) << w) - 1;
        a = longint'(x) & mask;
        b = longint'(y) & mask;
        if (a >= (longint'(1) << (w - 1))) a -= (longint'(1) << w);
        if (b >= (longint'(1) << (w - 1))) b -= (longint'(1) << w);
        p  = a * b;
        r  = rnd ? p + (longint'(1) << (f - 1)) : p;
        s  = r >>> f;
        mx = (longint'(1) << (w - 1)) - 1;
        mn = -(longint'(1) << (w - 1));
        ovf = (s > mx) || (s < mn);
        if (sat) res = (s > mx) ? mx : ((s < mn) ? mn : s);
        else     res = (s & mx) | ((r < 0) ? (mx + 1) : 0);
        res = res & mask;
        return {ovf, 32'(res)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (vld_a) begin
        if (qa.size() == 0) check("A_spurious_vld", 64'(vld_a), 64'(0));
        else begin
            ea = qa.pop_front();
            check("A_prod", 64'(prod_a), 64'(ea[15:0]));
            check("A_ovf", 64'(ovf_a), 64'(ea[32]));
        end
    end
    always @(negedge clk) if (vld_b) begin
        if (qb.size() == 0) check("B_spurious_vld", 64'(vld_b), 64'(0));
        else begin
            eb = qb.pop_front();
            check("B_prod", 64'(prod_b), 64'(eb[15:0]));
            check("B_ovf", 64'(ovf_b), 64'(eb[32]));
        end
    end
    always @(negedge clk) if (vld_c) begin
        if (qc.size() == 0) check("C_spurious_vld", 64'(vld_c), 64'(0));
        else begin
            ec = qc.pop_front();
            check("C_prod", 64'(prod_c), 64'(ec[7:0]));
            check("C_ovf", 64'(ovf_c), 64'(ec[32]));
        end
    end
    always @(negedge clk) if (vld_d) begin
        if (qd.size() == 0) check("D_spurious_vld", 64'(vld_d), 64'(0));
        else begin
            ed = qd.pop_front();
            check("D_prod", 64'(prod_d), 64'(ed[7:0]));
            check("D_ovf", 64'(ovf_d), 64'(ed[32]));
        end
    end

    // One operation: drive at a negedge, then watch each following cycle.
    // inj pulses foreign operands 3 and 10 cycles in; abort resets in cycle 5.
    task automatic run_op(bit w8, logic [31:0] a, logic [31:0] b, bit inj, bit abort);
        int n, lat, busy_n, seen;
        logic cur_vld, cur_busy;
        lat = w8 ? 9 : 17;
        n = 0;
        busy_n = 0;
        cur_vld = 1'b0;
        @(negedge clk);
        if (w8) begin
            m1_8 = a[7:0]; m2_8 = b[7:0]; vld8 = 1'b1;
            if (!abort) begin
                qc.push_back(model(8, 4, 1'b1, 1'b0, a, b));
                qd.push_back(model(8, 4, 1'b0, 1'b1, a, b));
            end
        end else begin
            m1_16 = a[15:0]; m2_16 = b[15:0]; vld16 = 1'b1;
            if (!abort) begin
                qa.push_back(model(16, 13, 1'b1, 1'b0, a, b));
                qb.push_back(model(16, 13, 1'b0, 1'b1, a, b));
            end
        end
        while (!cur_vld && n < lat + 20) begin
            @(negedge clk);
            n++;
            cur_vld  = w8 ? vld_c : vld_a;
            cur_busy = w8 ? busy_c : busy_a;
            vld8 = 1'b0;
            vld16 = 1'b0;
            if (cur_busy) busy_n++;
            if (inj && (n == 3 || n == 10)) begin
                m1_16 = ~a[15:0]; m2_16 = b[15:0] + 16'd5; vld16 = 1'b1;
            end
            if (abort && n == 5) rst = 1'b1;
            if (abort && n == 6) begin
                check("abort_busy", 64'(busy_a), 64'(0));
                check("abort_vld", 64'(vld_a), 64'(0));
                check("abort_prod", 64'(prod_a), 64'(0));
                check("abort_ovf", 64'(ovf_a), 64'(0));
                rst = 1'b0;
                seen = 0;
                repeat (40) begin
                    @(negedge clk);
                    seen += int'(vld_a);
                end
                check("abort_no_vld", 64'(seen), 64'(0));
                return;
            end
        end
        check(w8 ? "latency8" : "latency16", 64'(n), 64'(lat));
        check(w8 ? "busy_cycles8" : "busy_cycles16", 64'(busy_n), 64'(lat));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; vld16 = 1'b1; vld8 = 1'b1;
        m1_16 = 16'h2000; m2_16 = 16'h2000; m1_8 = 8'h10; m2_8 = 8'h10;
        repeat (3) @(negedge clk);
        check("rst_busy16", 64'(busy_a), 64'(0));
        check("rst_busy8", 64'(busy_c), 64'(0));
        check("rst_vld", 64'(vld_a), 64'(0));
        check("rst_prod", 64'(prod_a), 64'(0));
        check("rst_ovf", 64'(ovf_b), 64'(0));
        rst = 1'b0; vld16 = 1'b0; vld8 = 1'b0;

        run_op(1'b0, 32'h2000, 32'h2000, 1'b0, 1'b0);
        check("dir_1x1", 64'(prod_a), 64'h2000);
        check("dir_1x1_ovf", 64'(ovf_a), 64'h0);
        run_op(1'b0, 32'hE000, 32'h2000, 1'b0, 1'b0);
        check("dir_neg", 64'(prod_a), 64'hE000);
        run_op(1'b0, 32'h7FFF, 32'h7FFF, 1'b0, 1'b0);
        check("dir_max_sat", 64'(prod_a), 64'h7FFF);
        check("dir_max_wrap", 64'(prod_b), 64'h7FF8);
        check("dir_max_ovf", 64'(ovf_b), 64'h1);
        run_op(1'b0, 32'h8000, 32'h8000, 1'b0, 1'b0);
        check("dir_min_sat", 64'(prod_a), 64'h7FFF);
        check("dir_min_ovf", 64'(ovf_a), 64'h1);
        run_op(1'b0, 32'h0001, 32'h1000, 1'b0, 1'b0);
        check("dir_trunc", 64'(prod_a), 64'h0000);
        check("dir_round", 64'(prod_b), 64'h0001);
        run_op(1'b0, 32'h0000, 32'h8000, 1'b0, 1'b0);
        run_op(1'b0, 32'h8000, 32'h7FFF, 1'b0, 1'b0);
        run_op(1'b0, 32'h1234, 32'hABCD, 1'b1, 1'b0);
        run_op(1'b0, 32'h5555, 32'h2000, 1'b0, 1'b0);
        run_op(1'b0, 32'h4000, 32'h3000, 1'b0, 1'b1);
        run_op(1'b0, 32'h2000, 32'hC000, 1'b0, 1'b0);
        check("post_abort", 64'(prod_a), 64'hC000);

        run_op(1'b1, 32'h80, 32'h80, 1'b0, 1'b0);
        run_op(1'b1, 32'h7F, 32'h81, 1'b0, 1'b0);
        run_op(1'b1, 32'h00, 32'hFF, 1'b0, 1'b0);
        run_op(1'b1, 32'h01, 32'h08, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) run_op(1'b0, $urandom, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) run_op(1'b1, $urandom, $urandom, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_a_empty", 64'(qa.size()), 64'(0));
        check("sb_b_empty", 64'(qb.size()), 64'(0));
        check("sb_c_empty", 64'(qc.size()), 64'(0));
        check("sb_d_empty", 64'(qd.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
